md_issue_ctrl: RTL
==================

MD_ISSUE_CTRL -- requirements
Module: md_issue_ctrl

Interface
REQ-001 SHALL have parameter DIV_GUARD, default 2, meaning cycles after a div issue during which md_accessible is ignored.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req_valid  input  1  EX-stage HI/LO instruction present.
REQ-005 SHALL have port req_op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO.
REQ-006 SHALL have port req_src0  input  32  rs operand; req_src1  input  32  rt operand.
REQ-007 SHALL have port req_ready  output  1  request accepted this cycle.
REQ-008 SHALL have port flush  input  1  pipeline flush; drops the unaccepted request and any pending MF response.
REQ-009 SHALL have port md_op  output  6  one-hot pulse to HI/LO unit: bit0 mult, bit1 multu, bit2 div, bit3 divu, bit4 mthi, bit5 mtlo.
REQ-010 SHALL have port md_in0  output  32  and md_in1  output  32  operands; for MTHI md_in0=src0, for MTLO md_in1=src0.
REQ-011 SHALL have port md_read_hi  output  1  HI/LO read select (1 HI, 0 LO); md_rdata  input  32  HI/LO read data.
REQ-012 SHALL have port md_accessible  input  1  HI/LO unit idle and HI/LO valid.
REQ-013 SHALL have port rsp_valid  output  1  and rsp_data  output  32  registered MF result to WB.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, MUL_WB, DIV_GUARD_S, DIV_WAIT.
REQ-016 SHALL assert req_ready only in IDLE and when flush is low; accept = req_valid & req_ready.
REQ-017 SHALL drive md_op for exactly the accept cycle, zero otherwise; md_in0/md_in1 valid in that cycle only.
REQ-018 MULT/MULTU accept: IDLE -> MUL_WB for 1 cycle -> IDLE (HI/LO written one cycle after issue).
REQ-019 MTHI/MTLO accept: IDLE -> MUL_WB -> IDLE, same one-cycle write shadow.
REQ-020 DIV/DIVU accept: IDLE -> DIV_GUARD_S, hold DIV_GUARD cycles via counter, then DIV_WAIT; DIV_WAIT -> IDLE on first cycle md_accessible=1.
REQ-021 Divide-by-zero SHALL be issued unchanged; no exception raised here.
REQ-022 MFHI/MFLO accept in IDLE only: md_read_hi driven combinationally in accept cycle (1 for MFHI), md_rdata captured, rsp_valid=1 next cycle for one cycle.
REQ-023 md_read_hi SHALL hold its last MF value when no MF is accepted.
REQ-024 flush SHALL not abort an issued multiply/divide; FSM completes its sequence; flush in the cycle after an MF accept SHALL force rsp_valid=0.
REQ-025 flush and req_valid in same cycle: no accept, md_op=0.
REQ-026 Back-to-back MULT then MFLO: MFLO accepted no earlier than issue+2.

Reset
REQ-027 On rst: state IDLE, guard counter 0, md_op 0, md_in0/md_in1 0, md_read_hi 0, rsp_valid 0, rsp_data 0, busy 0, req_ready 0 during the reset cycle.
REQ-028 rst during DIV_WAIT SHALL return to IDLE next cycle regardless of md_accessible.

Structure
REQ-029 SHALL place req_op encodings, md_op bit indices and FSM state encodings in shared package md_pkg.
REQ-030 SHALL be a single module; guard counter inline, no sub-module.

Verification
REQ-031 MULT src0=3 src1=-2, then MFLO held valid -> md_op=6'b000001 at T, MFLO accepted T+2, rsp_data=32'hFFFFFFFA at T+3.
REQ-032 DIVU 100/7, md_accessible low until T+20 -> req_ready low T+1..T+20, IDLE T+21, MFHI returns 2, MFLO returns 14.
REQ-033 MTHI src0=32'hDEADBEEF -> md_op=6'b010000, md_in0=32'hDEADBEEF; MFHI at T+2 returns 32'hDEADBEEF.
REQ-034 flush asserted with req_valid MULT -> md_op stays 0, state IDLE; flush after MFHI accept -> rsp_valid 0.
REQ-035 rst asserted mid DIV_WAIT -> all outputs at reset values next cycle, req_ready=1 the cycle after rst deasserts.

Source files
------------

// File: rtl/md_pkg.sv
// Shared encodings for the HI/LO issue controller: request opcodes,
// HI/LO unit command bit positions and controller states.
package md_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MFHI  = 3'd6,
    OP_MFLO  = 3'd7
  } req_op_e;

  localparam int unsigned MD_OP_W  = 6;
  localparam int unsigned MD_MULT  = 0;
  localparam int unsigned MD_MULTU = 1;
  localparam int unsigned MD_DIV   = 2;
  localparam int unsigned MD_DIVU  = 3;
  localparam int unsigned MD_MTHI  = 4;
  localparam int unsigned MD_MTLO  = 5;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    MUL_WB      = 2'd1,
    DIV_GUARD_S = 2'd2,
    DIV_WAIT    = 2'd3
  } md_state_e;

endpackage

// File: rtl/md_issue_ctrl.sv
// EX-stage issue controller for HI/LO instructions: sequences mult/div/mt
// commands to the HI/LO unit and returns registered MFHI/MFLO results.
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int unsigned DIV_GUARD = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic [2:0]           req_op,
  input  logic [31:0]          req_src0,
  input  logic [31:0]          req_src1,
  output logic                 req_ready,
  input  logic                 flush,
  output logic [MD_OP_W-1:0]   md_op,
  output logic [31:0]          md_in0,
  output logic [31:0]          md_in1,
  output logic                 md_read_hi,
  input  logic [31:0]          md_rdata,
  input  logic                 md_accessible,
  output logic                 rsp_valid,
  output logic [31:0]          rsp_data,
  output logic                 busy
);

  localparam int unsigned GW = (DIV_GUARD > 1) ? $clog2(DIV_GUARD) : 1;

  md_state_e   state, state_d;
  logic [GW-1:0] cnt, cnt_d;
  req_op_e     op;
  logic        accept;
  logic        mf_accept;
  logic        rd_hi_q;
  logic        rsp_pend;
  logic [31:0] rsp_q;

  always_comb begin
    op        = req_op_e'(req_op);
    req_ready = (state == IDLE) && !flush && !rst;
    accept    = req_valid && req_ready;
    mf_accept = accept && (op == OP_MFHI || op == OP_MFLO);
    md_op     = '0;
    md_in0    = '0;
    md_in1    = '0;
    state_d   = state;
    cnt_d     = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              md_op[(op == OP_MULT) ? MD_MULT : MD_MULTU] = 1'b1;
              md_in0  = req_src0;
              md_in1  = req_src1;
              state_d = MUL_WB;
            end
            OP_DIV, OP_DIVU: begin
              md_op[(op == OP_DIV) ? MD_DIV : MD_DIVU] = 1'b1;
              md_in0  = req_src0;
              md_in1  = req_src1;
              cnt_d   = '0;
              state_d = (DIV_GUARD == 0) ? DIV_WAIT : DIV_GUARD_S;
            end
            OP_MTHI: begin
              md_op[MD_MTHI] = 1'b1;
              md_in0  = req_src0;
              state_d = MUL_WB;
            end
            OP_MTLO: begin
              md_op[MD_MTLO] = 1'b1;
              md_in1  = req_src0;
              state_d = MUL_WB;
            end
            default: ;
          endcase
        end
      end
      MUL_WB: state_d = IDLE;
      DIV_GUARD_S: begin
        // md_accessible may still reflect the pre-divide idle state here
        if (cnt == GW'(DIV_GUARD - 1)) begin
          cnt_d   = '0;
          state_d = DIV_WAIT;
        end else begin
          cnt_d = cnt + GW'(1);
        end
      end
      DIV_WAIT: if (md_accessible) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rd_hi_q  <= 1'b0;
      rsp_pend <= 1'b0;
      rsp_q    <= '0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      rsp_pend <= mf_accept;
      if (mf_accept) begin
        rd_hi_q <= (op == OP_MFHI);
        rsp_q   <= md_rdata;
      end
    end
  end

  always_comb begin
    md_read_hi = rst ? 1'b0 : (mf_accept ? (op == OP_MFHI) : rd_hi_q);
    rsp_valid  = rsp_pend && !flush && !rst;
    rsp_data   = rst ? '0 : rsp_q;
    busy       = !rst && (state != IDLE);
  end

endmodule
